// File: rtl/cla_multiword_add_seq_if.sv
// rtl/cla_multiword_add_seq_if.sv - operand/result handshake bundle for the multiword adder
interface cla_multiword_add_seq_if #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [WORD_W*NUM_WORDS-1:0]   a;
  logic [WORD_W*NUM_WORDS-1:0]   b;
  logic                          cin;
  logic                          sub;
  logic                          out_valid;
  logic                          out_ready;
  logic [WORD_W*NUM_WORDS-1:0]   sum;
  logic                          cout;
  logic                          ovf;
  logic                          busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla_multiword_add_seq.sv
// rtl/cla_multiword_add_seq.sv - wide add/subtract by sequencing one CLA slice over NUM_WORDS words
// Slice is built from 4-bit lookahead groups; group carries ripple, word carries live in carry_q.
module cla_multiword_add_seq #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cla_multiword_add_seq_if.slave  bus
);
  localparam int TOT_W = WORD_W * NUM_WORDS;
  localparam int NG    = WORD_W / 4;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TOT_W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [WORD_W-1:0]  op_a, op_b, p, g, slice_sum;
  logic [WORD_W:0]    c;

  assign op_a = a_q[idx_q*WORD_W +: WORD_W];
  assign op_b = b_q[idx_q*WORD_W +: WORD_W];
  assign p    = op_a ^ op_b;
  assign g    = op_a & op_b;

  always_comb begin
    logic gp, gg;
    c    = '0;
    gp   = 1'b0;
    gg   = 1'b0;
    c[0] = carry_q;
    for (int gi = 0; gi < NG; gi++) begin
      c[4*gi+1] = g[4*gi] | (p[4*gi] & c[4*gi]);
      c[4*gi+2] = g[4*gi+1] | (p[4*gi+1] & g[4*gi]) | (p[4*gi+1] & p[4*gi] & c[4*gi]);
      c[4*gi+3] = g[4*gi+2] | (p[4*gi+2] & g[4*gi+1]) | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & c[4*gi]);
      gg = g[4*gi+3] | (p[4*gi+3] & g[4*gi+2]) | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
         | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
      gp = p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & p[4*gi];
      c[4*gi+4] = gg | (gp & c[4*gi]);
    end
  end

  assign slice_sum = p ^ c[WORD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1, so it reuses the add path unchanged.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*WORD_W +: WORD_W] = slice_sum;
        carry_d = c[WORD_W];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = c[WORD_W];
          ovf_d   = c[WORD_W] ^ c[WORD_W-1];
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// tb/tb_cla_multiword_add_seq.sv - self-checking bench for cla_multiword_add_seq
module tb_cla_multiword_add_seq;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int TOT = W * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_multiword_add_seq_if #(.WORD_W(W), .NUM_WORDS(N)) bus ();

  cla_multiword_add_seq #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Returns {ovf, cout, sum} from plain wide arithmetic.
  function automatic logic [TOT+1:0] model(input logic [TOT-1:0] av, input logic [TOT-1:0] bv,
                                           input logic ci, input logic sb);
    logic [TOT:0] sx;
    logic [TOT:0] u;
    logic         co;
    if (sb) begin
      sx = {av[TOT-1], av} - {bv[TOT-1], bv};
      co = (av >= bv);
    end else begin
      sx = {av[TOT-1], av} + {bv[TOT-1], bv} + {{TOT{1'b0}}, ci};
      u  = {1'b0, av} + {1'b0, bv} + {{TOT{1'b0}}, ci};
      co = u[TOT];
    end
    return {sx[TOT] ^ sx[TOT-1], co, sx[TOT-1:0]};
  endfunction

  function automatic logic [TOT-1:0] rand_word();
    logic [TOT-1:0] r;
    int sel;
    sel = $urandom_range(0, 7);
    r   = {32'($urandom), 32'($urandom)};
    case (sel)
      0: r = '1;
      1: r = {1'b0, {(TOT-1){1'b1}}};
      2: r = {1'b1, {(TOT-1){1'b0}}};
      3: r = TOT'(W'($urandom));
      default: ;
    endcase
    return r;
  endfunction

  task automatic start_op(input logic [TOT-1:0] av, input logic [TOT-1:0] bv,
                          input logic ci, input logic sb, output int lat);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin @(posedge clk); #1; t++; end
    bus.a = av; bus.b = bv; bus.cin = ci; bus.sub = sb; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = {32'($urandom), 32'($urandom)};
    bus.b = {32'($urandom), 32'($urandom)};
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_op(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [TOT-1:0] av, input logic [TOT-1:0] bv, input logic ci,
                        input logic sb, input int hold, output int lat,
                        output logic [TOT-1:0] s, output logic co, output logic ov);
    start_op(av, bv, ci, sb, lat);
    s = bus.sum; co = bus.cout; ov = bus.ovf;
    finish_op(hold);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum got %h want 0", bus.sum); end
    checks++; if ({bus.cout, bus.ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf got %b want 00", {bus.cout, bus.ovf}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_chain();
    int lat; logic [TOT-1:0] s; logic co, ov;
    run_op('1, 64'h1, 1'b0, 1'b0, 0, lat, s, co, ov);
    checks++; if (lat !== N) begin errors++; $display("FAIL chain_latency got %0d want %0d", lat, N); end
    checks++; if (s !== '0) begin errors++; $display("FAIL chain_sum got %h want 0", s); end
    checks++; if ({co, ov} !== 2'b10) begin errors++; $display("FAIL chain_cout_ovf got %b want 10", {co, ov}); end
  endtask

  task automatic test_word_boundary();
    logic [TOT-1:0] va [2] = '{64'h0000_0000_0000_FFFF, 64'h0};
    logic [TOT-1:0] vb [2] = '{64'h1, 64'h0};
    logic           vc [2] = '{1'b0, 1'b1};
    logic [TOT-1:0] es [2] = '{64'h0000_0000_0001_0000, 64'h1};
    int lat; logic [TOT-1:0] s; logic co, ov;
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, 1, lat, s, co, ov);
      checks++; if (s !== es[i]) begin errors++; $display("FAIL boundary_sum[%0d] got %h want %h", i, s, es[i]); end
      checks++; if ({co, ov} !== 2'b00) begin errors++; $display("FAIL boundary_cout_ovf[%0d] got %b want 00", i, {co, ov}); end
    end
  endtask

  task automatic test_subtract();
    logic [TOT-1:0] va [2] = '{64'd5, 64'd7};
    logic [TOT-1:0] vb [2] = '{64'd7, 64'd5};
    logic [TOT-1:0] es [2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h2};
    logic           ec [2] = '{1'b0, 1'b1};
    int lat; logic [TOT-1:0] s; logic co, ov;
    for (int i = 0; i < 2; i++) begin
      // cin=1 must be ignored for subtraction
      run_op(va[i], vb[i], 1'b1, 1'b1, 0, lat, s, co, ov);
      checks++; if (s !== es[i]) begin errors++; $display("FAIL sub_sum[%0d] got %h want %h", i, s, es[i]); end
      checks++; if ({co, ov} !== {ec[i], 1'b0}) begin errors++; $display("FAIL sub_cout_ovf[%0d] got %b want %b0", i, {co, ov}, ec[i]); end
    end
  endtask

  task automatic test_overflow();
    int lat; logic [TOT-1:0] s; logic co, ov;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, lat, s, co, ov);
    checks++; if (s !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_sum got %h want 8000000000000000", s); end
    checks++; if ({co, ov} !== 2'b01) begin errors++; $display("FAIL ovf_flags got %b want 01", {co, ov}); end
  endtask

  task automatic test_backpressure();
    int lat; logic [TOT+1:0] exp;
    logic [TOT-1:0] av, bv;
    av = rand_word(); bv = rand_word();
    exp = model(av, bv, 1'b1, 1'b0);
    start_op(av, bv, 1'b1, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      bus.a = rand_word(); bus.b = rand_word(); bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if ({bus.ovf, bus.cout, bus.sum} !== exp) begin errors++; $display("FAIL bp_hold[%0d] got %h want %h", i, {bus.ovf, bus.cout, bus.sum}, exp); end
      checks++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL bp_flags[%0d] got %b want 10", i, {bus.out_valid, bus.in_ready}); end
    end
    // in_valid stays high across the result handshake and must not be taken
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    checks++; if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin errors++; $display("FAIL bp_release got %b want 100", {bus.in_ready, bus.busy, bus.out_valid}); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [TOT-1:0] s; logic co, ov;
    bus.a = 64'h1111_1111_1111_1111; bus.b = 64'h2222_2222_2222_2222;
    bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL midrst_flags got %b want 00", {bus.out_valid, bus.busy}); end
    checks++; if (bus.sum !== '0) begin errors++; $display("FAIL midrst_sum got %h want 0", bus.sum); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
    run_op(64'd3, 64'd4, 1'b0, 1'b0, 0, lat, s, co, ov);
    checks++; if (s !== 64'd7) begin errors++; $display("FAIL midrst_fresh_sum got %h want 7", s); end
  endtask

  task automatic test_random();
    int lat; logic [TOT-1:0] s, av, bv; logic co, ov, ci, sb;
    logic [TOT+1:0] exp;
    for (int i = 0; i < 30; i++) begin
      av = rand_word(); bv = rand_word();
      ci = 1'($urandom); sb = 1'($urandom);
      exp = model(av, bv, ci, sb);
      run_op(av, bv, ci, sb, $urandom_range(0, 3), lat, s, co, ov);
      checks++; if ({ov, co, s} !== exp) begin errors++; $display("FAIL rand[%0d] a=%h b=%h ci=%b sub=%b got %h want %h", i, av, bv, ci, sb, {ov, co, s}, exp); end
      checks++; if (lat !== N) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, N); end
    end
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int t, lat;
    logic [TOT-1:0] av, bv; logic ci;
    logic [TOT+1:0] exp;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!bus.in_ready && t < 20) begin @(posedge clk); #1; t++; end
      av = rand_word(); bv = rand_word(); ci = 1'($urandom);
      bus.a = av; bus.b = bv; bus.cin = ci;
      exp = model(av, bv, ci, 1'b0);
      @(posedge clk); #1;
      acc[i] = cyc;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      checks++; if ({bus.ovf, bus.cout, bus.sum} !== exp) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, {bus.ovf, bus.cout, bus.sum}, exp); end
      if (i > 0) begin
        checks++; if (acc[i] - acc[i-1] !== N + 2) begin errors++; $display("FAIL b2b_interval[%0d] got %0d want %0d", i, acc[i] - acc[i-1], N + 2); end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    test_reset();
    test_carry_chain();
    test_word_boundary();
    test_subtract();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_multiword_add_seq.md
Name: cla_multiword_add_seq

Overview:
- Sequencer that runs a single WORD_W-bit carry-lookahead adder slice over NUM_WORDS cycles to add or subtract wide operands, least-significant word first.
- The inter-word carry is held in a register between cycles.
- The slice is built inside the block from 4-bit lookahead groups (group P/G, rippled between groups).
- Operands arrive in parallel over a valid/ready handshake; the result leaves over a second valid/ready handshake. The block sits between an operand source and any consumer of wide sums.

Parameters:
- WORD_W, 16, width of the adder slice; must be a multiple of 4.
- NUM_WORDS, 4, number of slice passes; operand width is WORD_W*NUM_WORDS; must be >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WORD_W*NUM_WORDS  operand A.
- b  input  WORD_W*NUM_WORDS  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1 = compute A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WORD_W*NUM_WORDS  result.
- cout  output  1  final carry-out (for sub: 1 = no borrow).
- ovf  output  1  signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; word index, carry register, sum, cout and ovf clear to 0.
  - out_valid=0, busy=0; in_ready=1 once state is IDLE.
- States:
  - IDLE: in_ready=1. On in_valid at a clock edge, capture a, the effective B (b, or ~b when sub=1) and the initial carry (cin, or 1 when sub=1). Clear the index and go to RUN.
  - RUN: each cycle, add word[idx] of the captured A and B plus the carry register. Write the slice sum into sum[idx*WORD_W +: WORD_W]. Store the slice carry-out in the carry register; idx increments.
  - RUN exit: when idx=NUM_WORDS-1, register cout = slice carry-out and ovf = carry-into-MSB XOR carry-out of MSB, then go to DONE.
  - DONE: out_valid=1. sum, cout and ovf are held stable until out_ready=1, then go to IDLE.
- Latency:
  - Accept at edge k; out_valid rises after edge k+NUM_WORDS.
  - The next accept is possible at the edge after the out_ready handshake. Throughput is therefore one operation per NUM_WORDS+2 cycles when out_ready is held high.
- Handshake rules:
  - in_ready=0 outside IDLE. in_valid while busy is ignored; no queuing.
  - Operand inputs are sampled only at the accept edge and may change afterwards.
  - out_valid does not drop without out_ready.
  - out_ready while not in DONE has no effect.
- Arithmetic:
  - All arithmetic is modulo 2^(WORD_W*NUM_WORDS).
  - Carry propagates across word boundaries only through the carry register.
  - The slice is pure combinational: per-bit p=a^b, g=a&b; 4-bit groups produce internal carries plus group P/G; group carries ripple.
- sum contents during RUN:
  - Words not yet computed hold stale contents (zero after reset, else the previous result).
  - sum is only meaningful while out_valid=1.
- Reset mid-operation: the operation is abandoned and all outputs go to reset values immediately; no result is emitted.
- Simultaneous in_valid and out_ready in DONE: the result handshake completes and the operands are not accepted that cycle.

Test Plan:
- Carry chain (defaults): a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0, cout=1, ovf=0.
- Word-boundary carry: a=0x0000_0000_0000_FFFF, b=0x1 -> sum=0x0000_0000_0001_0000, cout=0. Also cin=1 with a=b=0 -> sum=0x1.
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then a=7, b=5 -> sum=0x2, cout=1.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, and pulse in_valid with new operands meanwhile -> sum/cout/ovf stable, in_ready=0, new operands ignored. After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 at idx=2 -> out_valid=0, busy=0, sum=0 immediately. After release, in_ready=1 and a fresh add of 3+4 returns sum=7.
